// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment scan controller.
//   SEG_BLANK   - active-low pattern with every segment off
//   DIGITS_DEF  - default number of scanned digits
//   DIV_DEF     - default clock cycles per digit slot
//   MAX_DIGITS  - widest digit bank the display-set typedef can hold
//   disp_set_t  - one display set: hex nibbles, per-digit enables, lz flag
package seg_pkg;

  localparam int DIGITS_DEF = 8;
  localparam int DIV_DEF    = 1000;
  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Digit k lives in nib[4k+3:4k] and en[k]; bits above the configured
  // digit count are held at zero.
  typedef struct packed {
    logic [4*MAX_DIGITS-1:0] nib;
    logic [MAX_DIGITS-1:0]   en;
    logic                    lz;
  } disp_set_t;

endpackage

// File: rtl/segment.sv
// segment: hex-to-seven-segment decoder, active-low outputs.
//   data - hex nibble to show
//   en   - 0 forces every segment off
//   seg  - {g,f,e,d,c,b,a}, 0 lights a segment
module segment
  import seg_pkg::*;
(
  input  logic [3:0] data,
  input  logic       en,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (en) begin
      case (data)
        4'h0:    seg = 7'b1000000;
        4'h1:    seg = 7'b1111001;
        4'h2:    seg = 7'b0100100;
        4'h3:    seg = 7'b0110000;
        4'h4:    seg = 7'b0011001;
        4'h5:    seg = 7'b0010010;
        4'h6:    seg = 7'b0000010;
        4'h7:    seg = 7'b1111000;
        4'h8:    seg = 7'b0000000;
        4'h9:    seg = 7'b0010000;
        4'hA:    seg = 7'b0001000;
        4'hB:    seg = 7'b0000011;
        4'hC:    seg = 7'b1000110;
        4'hD:    seg = 7'b0100001;
        4'hE:    seg = 7'b0000110;
        default: seg = 7'b0001110;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// seven-segment bank sharing a single hex decoder.
//   clk, rst          - clock, synchronous active-high reset
//   wr_valid/wr_ready - write handshake for a new display set
//   wr_data           - hex nibbles, digit k at [4k+3:4k]
//   wr_en             - per-digit enable, 0 blanks the digit
//   lz_blank          - leading-zero blanking mode for this write
//   seg               - active-low segment pattern (registered)
//   an                - active-low digit select (registered)
//   frame_done        - one-cycle pulse after the scan wraps to digit 0
// New contents are held in a pending set and copied to the active set
// only on the frame-boundary cycle, so a frame never mixes two writes.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int DIV    = DIV_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic [DIGITS-1:0]     wr_en,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0]  cnt_reg;
  logic [IDX_W-1:0]  idx_reg;
  disp_set_t         active_reg;
  disp_set_t         pend_reg;
  logic              pend_full_reg;
  logic [6:0]        seg_reg;
  logic [DIGITS-1:0] an_reg;
  logic              frame_done_reg;

  logic              slot_end;
  logic              frame_wrap;
  logic              accept;
  disp_set_t         wr_payload;
  logic [DIGITS:0]   zero_above;
  logic [DIGITS-1:0] blank_vec;
  logic [3:0]        cur_nib;
  logic              cur_en;
  logic [6:0]        seg_next;
  logic [DIGITS-1:0] an_next;

  assign slot_end   = (cnt_reg == CNT_LAST);
  assign frame_wrap = slot_end && (idx_reg == IDX_LAST);
  assign wr_ready   = !pend_full_reg;
  assign accept     = wr_valid && !pend_full_reg;

  always_comb begin
    wr_payload                   = '0;
    wr_payload.nib[4*DIGITS-1:0] = wr_data;
    wr_payload.en[DIGITS-1:0]    = wr_en;
    wr_payload.lz                = lz_blank;
  end

  // zero_above[k] is set when every active nibble from the top digit down
  // to digit k is zero; digit 0 is exempt so a zero value still shows "0".
  assign zero_above[DIGITS] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign zero_above[gi] = (active_reg.nib[4*gi +: 4] == 4'h0) && zero_above[gi+1];
      if (gi == 0) begin : g_lsd
        assign blank_vec[gi] = !active_reg.en[gi];
      end else begin : g_upper
        assign blank_vec[gi] = !active_reg.en[gi] || (active_reg.lz && zero_above[gi]);
      end
    end
  endgenerate

  // Select the current digit's nibble and enable for the shared decoder.
  always_comb begin
    cur_nib = 4'h0;
    cur_en  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_reg == IDX_W'(k)) begin
        cur_nib = active_reg.nib[4*k +: 4];
        cur_en  = !blank_vec[k];
      end
    end
  end

  segment u_segment (
    .data (cur_nib),
    .en   (cur_en),
    .seg  (seg_next)
  );

  // The first cycle of each slot keeps every anode off to avoid ghosting
  // while the segment lines settle on the new digit.
  always_comb begin
    an_next = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if ((cnt_reg != '0) && (idx_reg == IDX_W'(k))) begin
        an_next[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      active_reg     <= '0;
      pend_reg       <= '0;
      pend_full_reg  <= 1'b0;
      seg_reg        <= SEG_BLANK;
      an_reg         <= '1;
      frame_done_reg <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt_reg <= '0;
        idx_reg <= frame_wrap ? '0 : idx_reg + 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      // A full pending set blocks new writes, so a commit and an accept
      // never fall on the same cycle.
      if (frame_wrap && pend_full_reg) begin
        active_reg    <= pend_reg;
        pend_full_reg <= 1'b0;
      end else if (accept) begin
        pend_reg      <= wr_payload;
        pend_full_reg <= 1'b1;
      end

      seg_reg        <= seg_next;
      an_reg         <= an_next;
      frame_done_reg <= frame_wrap;
    end
  end

  assign seg        = seg_reg;
  assign an         = an_reg;
  assign frame_done = frame_done_reg;

endmodule
